// File: rtl/dot_reduce_pkg.sv
// Shared types and helpers for leaf stream operators built on the ap_vld/ap_ack handshake.
package dot_reduce_pkg;

    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  vld;
    } hs_word_t;

    // Single 3-operand sum; carries out of the top bit are dropped (mod 2^W).
    function automatic logic [DEF_DATA_W-1:0] wrap_add3(
        input logic [DEF_DATA_W-1:0] a,
        input logic [DEF_DATA_W-1:0] b,
        input logic [DEF_DATA_W-1:0] c
    );
        return a + b + c;
    endfunction

endpackage

// File: rtl/dot_reduce_2_hs_out_reg.sv
// Single-entry output register: load sets valid, downstream ack clears it.
module hs_out_reg #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ack,
    output logic [W-1:0] o_data,
    output logic         o_vld
);

    logic [W-1:0] r_data;
    logic         r_vld;

    // A load wins over a same-cycle ack so a fresh result is never dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_vld  <= 1'b1;
        end else if (r_vld && i_ack) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld;

endmodule

// File: rtl/dot_reduce_2.sv
// Joins the two dotProduct_2 partial streams and sums NUM_PARTIALS pairs per result word.
module dot_reduce_2
    import dot_reduce_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int NUM_PARTIALS = 16,
    parameter int CNT_W        = $clog2(NUM_PARTIALS)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [DATA_W-1:0] Input_1_V_V,
    input  logic              Input_1_V_V_ap_vld,
    output logic              Input_1_V_V_ap_ack,
    input  logic [DATA_W-1:0] Input_2_V_V,
    input  logic              Input_2_V_V_ap_vld,
    output logic              Input_2_V_V_ap_ack,
    output logic [DATA_W-1:0] Output_1_V_V,
    output logic              Output_1_V_V_ap_vld,
    input  logic              Output_1_V_V_ap_ack
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PARTIALS - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_acc;
    logic              w_out_vld;
    logic              w_last;
    logic              w_stall;
    logic              w_in_ack;
    logic [DATA_W-1:0] w_base;
    logic [DATA_W-1:0] w_sum;
    hs_word_t          w_ld;

    // Stall only on the final pair while the previous result is still pending,
    // so downstream ack never reaches the input acks combinationally.
    assign w_last   = (r_cnt == LAST);
    assign w_stall  = w_last & w_out_vld;
    assign w_in_ack = ap_rst_n & Input_1_V_V_ap_vld & Input_2_V_V_ap_vld & ~w_stall;

    assign Input_1_V_V_ap_ack = w_in_ack;
    assign Input_2_V_V_ap_ack = w_in_ack;

    assign w_base = (r_cnt == '0) ? '0 : r_acc;
    assign w_sum  = wrap_add3(w_base, Input_1_V_V, Input_2_V_V);

    always_comb begin
        w_ld      = '0;
        w_ld.data = w_sum;
        w_ld.vld  = w_in_ack & w_last;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_in_ack) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_acc <= w_sum;
            end
        end
    end

    hs_out_reg #(.W(DATA_W)) u_out (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_load  (w_ld.vld),
        .i_data  (w_ld.data),
        .i_ack   (Output_1_V_V_ap_ack),
        .o_data  (Output_1_V_V),
        .o_vld   (w_out_vld)
    );

    assign Output_1_V_V_ap_vld = w_out_vld;

endmodule

// File: tb/tb_dot_reduce_2.sv
// Directed bench for dot_reduce_2 with NUM_PARTIALS=4: vector table plus join, backpressure and reset sequences.
module tb_dot_reduce_2;

    localparam int NP = 4;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [31:0] in1, in2;
    logic        in1_vld, in2_vld;
    logic        in1_ack, in2_ack;
    logic [31:0] out_data;
    logic        out_vld;
    logic        out_ack;

    int n_checks = 0;
    int n_fail   = 0;

    dot_reduce_2 #(.DATA_W(32), .NUM_PARTIALS(NP)) dut (
        .ap_clk              (ap_clk),
        .ap_rst_n            (ap_rst_n),
        .Input_1_V_V         (in1),
        .Input_1_V_V_ap_vld  (in1_vld),
        .Input_1_V_V_ap_ack  (in1_ack),
        .Input_2_V_V         (in2),
        .Input_2_V_V_ap_vld  (in2_vld),
        .Input_2_V_V_ap_ack  (in2_ack),
        .Output_1_V_V        (out_data),
        .Output_1_V_V_ap_vld (out_vld),
        .Output_1_V_V_ap_ack (out_ack)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        string       name;
        logic [31:0] a [NP];
        logic [31:0] b [NP];
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Lands 1 time unit after the rising edge, away from it.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_in(input logic v1, input logic [31:0] a, input logic v2, input logic [31:0] b);
        in1_vld = v1; in1 = a;
        in2_vld = v2; in2 = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{name:"basic",  a:'{32'd1, 32'd3, 32'd5, 32'd7}, b:'{32'd2, 32'd4, 32'd6, 32'd8}, exp:32'd36};
        vecs[1] = '{name:"wrap",   a:'{32'h7FFFFFFF, 32'd0, 32'd0, 32'd0}, b:'{32'd1, 32'd0, 32'd0, 32'd0}, exp:32'h80000000};
        vecs[2] = '{name:"swrap",  a:'{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                                   b:'{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, exp:32'hFFFFFFF8};
        vecs[3] = '{name:"mixed",  a:'{32'h10, 32'hFFFFFFFF, 32'd0, 32'd100}, b:'{32'h20, 32'd0, 32'd1, 32'd200}, exp:32'd348};

        // Reset with both inputs valid: acks must still be held low.
        ap_rst_n = 1'b0;
        out_ack  = 1'b1;
        set_in(1'b1, 32'd9, 1'b1, 32'd9);
        #1;
        chk("rst_data", out_data, 32'd0);
        chk("rst_vld",  {31'd0, out_vld}, 32'd0);
        chk("rst_ack1", {31'd0, in1_ack}, 32'd0);
        chk("rst_ack2", {31'd0, in2_ack}, 32'd0);
        set_in(1'b0, 32'd0, 1'b0, 32'd0);
        tick(); tick();
        ap_rst_n = 1'b1;
        tick();

        // Table vectors: back-to-back pairs, output ack held 1.
        foreach (vecs[v]) begin
            for (int k = 0; k < NP; k++) begin
                set_in(1'b1, vecs[v].a[k], 1'b1, vecs[v].b[k]);
                #1;
                chk({vecs[v].name, "_ack"}, {31'd0, in1_ack & in2_ack}, 32'd1);
                if (k == 0 || k == NP-1)
                    chk({vecs[v].name, "_novld"}, {31'd0, out_vld}, 32'd0);
                tick();
            end
            set_in(1'b0, 32'd0, 1'b0, 32'd0);
            chk({vecs[v].name, "_vld"},  {31'd0, out_vld}, 32'd1);
            chk({vecs[v].name, "_data"}, out_data, vecs[v].exp);
            tick();
            chk({vecs[v].name, "_vld1cyc"}, {31'd0, out_vld}, 32'd0);
        end

        // Join: a lone valid on Input_1 is never acked.
        set_in(1'b1, 32'd1, 1'b0, 32'd1);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("join_lone_ack1", {31'd0, in1_ack}, 32'd0);
            chk("join_lone_ack2", {31'd0, in2_ack}, 32'd0);
            tick();
        end
        set_in(1'b1, 32'd1, 1'b1, 32'd1);
        #1;
        chk("join_pair_ack", {31'd0, in1_ack & in2_ack}, 32'd1);
        tick();
        tick(); tick(); tick();
        set_in(1'b0, 32'd0, 1'b0, 32'd0);
        chk("join_result", out_data, 32'd8);
        chk("join_vld", {31'd0, out_vld}, 32'd1);
        tick();

        // Backpressure: output ack low, stream of (1,1).
        out_ack = 1'b0;
        set_in(1'b1, 32'd1, 1'b1, 32'd1);
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("bp_accept", {31'd0, in1_ack & in2_ack}, 32'd1);
            if (i >= NP) begin
                chk("bp_hold_vld",  {31'd0, out_vld}, 32'd1);
                chk("bp_hold_data", out_data, 32'd8);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_stall_ack1", {31'd0, in1_ack}, 32'd0);
            chk("bp_stall_ack2", {31'd0, in2_ack}, 32'd0);
            chk("bp_stall_data", out_data, 32'd8);
            tick();
        end
        out_ack = 1'b1;
        #1;
        chk("bp_ack_no_comb", {31'd0, in1_ack}, 32'd0);
        tick();
        out_ack = 1'b0;
        #1;
        chk("bp_drained_vld", {31'd0, out_vld}, 32'd0);
        chk("bp_4th_accept",  {31'd0, in1_ack & in2_ack}, 32'd1);
        tick();
        set_in(1'b0, 32'd0, 1'b0, 32'd0);
        chk("bp_res2_vld",  {31'd0, out_vld}, 32'd1);
        chk("bp_res2_data", out_data, 32'd8);
        out_ack = 1'b1;
        tick();
        chk("bp_res2_clear", {31'd0, out_vld}, 32'd0);

        // Reset mid-vector: partial sum of 40 must not leak into the next result.
        set_in(1'b1, 32'd10, 1'b1, 32'd10);
        tick(); tick();
        #3;
        ap_rst_n = 1'b0;
        #1;
        chk("mrst_data", out_data, 32'd0);
        chk("mrst_vld",  {31'd0, out_vld}, 32'd0);
        chk("mrst_ack",  {31'd0, in1_ack | in2_ack}, 32'd0);
        tick();
        ap_rst_n = 1'b1;
        set_in(1'b1, 32'd1, 1'b1, 32'd0);
        for (int k = 0; k < NP; k++) begin
            #1;
            chk("mrst_accept", {31'd0, in1_ack & in2_ack}, 32'd1);
            tick();
        end
        set_in(1'b0, 32'd0, 1'b0, 32'd0);
        chk("mrst_vld_after",  {31'd0, out_vld}, 32'd1);
        chk("mrst_data_after", out_data, 32'd4);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
